image_proc_frame_sequencer: RTL and testbench
=============================================

Name: image_proc_frame_sequencer

Overview:
- AXI4-Lite master that configures and sequences the image_processor_top HLS core over its CONTROL_BUS slave.
- Per run: programs rows/cols and interrupt enables, then issues ap_start once per frame and waits for the core interrupt.
- After each interrupt: reads AP_CTRL, then acknowledges the ISR.
- Sits beside the processor core in the video pipeline. Replaces software polling of the control bus.

Parameters:
- ADDR_WIDTH, 5, control-bus address width.
- DATA_WIDTH, 32, control-bus data width.
- TIMEOUT_CYCLES, 2000000, max aclk cycles in WAIT_IRQ before error; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a run
- stop  in  1  single-cycle pulse; ends the run after the current frame
- frame_rows  in  16  sampled at start
- frame_cols  in  16  sampled at start
- num_frames  in  16  sampled at start; 0 = continuous until stop
- interrupt  in  1  level interrupt from the core
- m_axi_AWADDR  out  ADDR_WIDTH
- m_axi_AWVALID  out  1
- m_axi_AWREADY  in  1
- m_axi_WDATA  out  DATA_WIDTH
- m_axi_WSTRB  out  4
- m_axi_WVALID  out  1
- m_axi_WREADY  in  1
- m_axi_BRESP  in  2
- m_axi_BVALID  in  1
- m_axi_BREADY  out  1
- m_axi_ARADDR  out  ADDR_WIDTH
- m_axi_ARVALID  out  1
- m_axi_ARREADY  in  1
- m_axi_RDATA  in  DATA_WIDTH
- m_axi_RRESP  in  2
- m_axi_RVALID  in  1
- m_axi_RREADY  out  1
- busy  out  1  high in any state other than IDLE
- frames_done  out  16  frames completed in the current run; wraps 0xFFFF->0
- error  out  1  sticky; cleared by the next accepted start
- err_code  out  2  0 none, 1 BRESP/RRESP not OKAY, 2 timeout, 3 ap_done not set on readback

Behaviour:
- Reset (areset high, asynchronous):
  - FSM to IDLE.
  - All VALID/READY outputs 0; addresses and data 0.
  - busy=0, frames_done=0, error=0, err_code=0.
  - Reset mid-transaction abandons the transaction; no completion is issued.
- Core register map:
  - 0x00 AP_CTRL (bit0 ap_start, bit1 ap_done)
  - 0x04 GIE
  - 0x08 IER
  - 0x0C ISR (toggle-on-write)
  - 0x10 rows
  - 0x14 cols
- WSTRB is always 4'hF.
- Write transaction:
  - AWVALID and WVALID assert in the same cycle.
  - Each drops independently on the cycle after its own handshake.
  - BREADY asserts after both handshakes complete; the transaction finishes on BVALID&BREADY.
- Read transaction:
  - ARVALID is held until ARREADY.
  - RREADY is then asserted and the transaction finishes on RVALID&RREADY.
- FSM states: IDLE, W_ROWS(0x10=rows), W_COLS(0x14=cols), W_GIE(0x04=1), W_IER(0x08=1), W_START(0x00=1), WAIT_IRQ, R_STAT(read 0x00), W_ACK(0x0C=1), DONE_CHK.
- IDLE:
  - start=1 latches rows/cols/num_frames, clears frames_done and error, then goes to W_ROWS.
  - start while busy is ignored.
- W_ROWS -> W_COLS -> W_GIE -> W_IER -> W_START, each on B completion.
- W_START -> WAIT_IRQ on B completion; the timeout counter clears.
- WAIT_IRQ:
  - interrupt=1 -> R_STAT.
  - Counter reaching TIMEOUT_CYCLES -> error=1, err_code=2, IDLE.
- R_STAT:
  - Captures RDATA.
  - bit1=0 -> err_code=3, error, IDLE.
  - Otherwise -> W_ACK.
- W_ACK:
  - B completion -> frames_done+1 (same cycle), then DONE_CHK.
- DONE_CHK (1 cycle):
  - If stop_pending, or (num_frames!=0 and frames_done==num_frames) -> IDLE.
  - Otherwise -> W_START. Rows/cols are not rewritten.
- stop:
  - Any stop pulse while busy sets stop_pending; it clears on entering IDLE.
  - stop in IDLE has no effect.
  - start and stop in the same cycle in IDLE: start wins and stop_pending is set, so exactly one frame runs.
- Response errors:
  - BRESP!=0 or RRESP!=0 -> error=1, err_code=1, IDLE immediately after the response handshake.
- Outstanding limits: at most one read or write transaction outstanding; never concurrent read and write.
- Minimum latency from start to first AWVALID: 1 cycle.

Test Plan:
- Zero-wait slave; rows=480, cols=640, num_frames=2; interrupt 100 cycles after each ap_start write.
  - Write sequence must be 0x10=480, 0x14=640, 0x04=1, 0x08=1, 0x00=1, then read 0x00, then 0x0C=1, 0x00=1, read 0x00, 0x0C=1.
  - End state: frames_done=2, busy=0, error=0.
- Slave holding AWREADY low 3 cycles and WREADY low 7 cycles.
  - AWVALID and WVALID drop independently.
  - BREADY only after both handshakes; exactly one B per write.
- num_frames=0; stop pulsed mid-WAIT_IRQ of frame 3.
  - Frame 3 completes its ack, then IDLE; frames_done=3.
- TIMEOUT_CYCLES=50; interrupt never asserted.
  - IDLE after 50 WAIT_IRQ cycles with error=1, err_code=2.
  - A subsequent start clears error.
- BRESP=2'b10 on the W_GIE write.
  - error=1, err_code=1, IDLE; no W_IER write issued.
- areset pulsed while ARVALID=1 in R_STAT.
  - All outputs at reset values immediately.
  - A new start runs normally from W_ROWS.

Source files
------------

// File: rtl/image_proc_frame_sequencer_if.sv
// AXI4-Lite control-bus bundle between the frame sequencer (master) and the
// image_processor_top CONTROL_BUS slave.
interface image_proc_frame_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_axi_AWADDR;
    logic                  m_axi_AWVALID;
    logic                  m_axi_AWREADY;
    logic [DATA_WIDTH-1:0] m_axi_WDATA;
    logic [3:0]            m_axi_WSTRB;
    logic                  m_axi_WVALID;
    logic                  m_axi_WREADY;
    logic [1:0]            m_axi_BRESP;
    logic                  m_axi_BVALID;
    logic                  m_axi_BREADY;
    logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
    logic                  m_axi_ARVALID;
    logic                  m_axi_ARREADY;
    logic [DATA_WIDTH-1:0] m_axi_RDATA;
    logic [1:0]            m_axi_RRESP;
    logic                  m_axi_RVALID;
    logic                  m_axi_RREADY;

    modport master (
        output m_axi_AWADDR, m_axi_AWVALID, m_axi_WDATA, m_axi_WSTRB, m_axi_WVALID,
               m_axi_BREADY, m_axi_ARADDR, m_axi_ARVALID, m_axi_RREADY,
        input  m_axi_AWREADY, m_axi_WREADY, m_axi_BRESP, m_axi_BVALID,
               m_axi_ARREADY, m_axi_RDATA, m_axi_RRESP, m_axi_RVALID
    );

    modport slave (
        input  m_axi_AWADDR, m_axi_AWVALID, m_axi_WDATA, m_axi_WSTRB, m_axi_WVALID,
               m_axi_BREADY, m_axi_ARADDR, m_axi_ARVALID, m_axi_RREADY,
        output m_axi_AWREADY, m_axi_WREADY, m_axi_BRESP, m_axi_BVALID,
               m_axi_ARREADY, m_axi_RDATA, m_axi_RRESP, m_axi_RVALID
    );
endinterface

// File: rtl/image_proc_frame_sequencer.sv
// AXI4-Lite master that programs the image_processor_top core once per run and
// then starts it frame by frame, servicing its interrupt after each frame.
module image_proc_frame_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] frame_rows,
    input  logic [15:0] frame_cols,
    input  logic [15:0] num_frames,
    input  logic        interrupt,
    image_proc_frame_sequencer_if.master axi,
    output logic        busy,
    output logic [15:0] frames_done,
    output logic        error,
    output logic [1:0]  err_code
);
    typedef enum logic [3:0] {
        StIdle, StWRows, StWCols, StWGie, StWIer, StWStart,
        StWaitIrq, StRStat, StWAck, StDoneChk
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] RegCtrl = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] RegGie  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] RegIer  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] RegIsr  = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] RegRows = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] RegCols = ADDR_WIDTH'(8'h14);
    localparam logic [DATA_WIDTH-1:0] One     = DATA_WIDTH'(1);
    localparam logic [31:0]           TmoLast = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e                state_q, state_d;
    logic [15:0]           cols_q, num_q, frames_q;
    logic                  err_q, stop_pend_q;
    logic [1:0]            code_q;
    logic [31:0]           tmo_q;
    logic                  awvalid_q, wvalid_q, aw_done_q, w_done_q, bready_q;
    logic                  arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  aw_hs, w_hs, wr_done, ar_hs, rd_done, start_ok;
    logic                  err_set, ack_done, wr_issue, rd_issue;
    logic [1:0]            err_val;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign aw_hs    = awvalid_q & axi.m_axi_AWREADY;
    assign w_hs     = wvalid_q & axi.m_axi_WREADY;
    assign wr_done  = bready_q & axi.m_axi_BVALID;
    assign ar_hs    = arvalid_q & axi.m_axi_ARREADY;
    assign rd_done  = rready_q & axi.m_axi_RVALID;
    assign start_ok = (state_q == StIdle) & start;

    always_comb begin
        state_d  = state_q;
        err_set  = 1'b0;
        err_val  = 2'd0;
        ack_done = 1'b0;
        wr_issue = 1'b0;
        rd_issue = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        unique case (state_q)
            StIdle: if (start) state_d = StWRows;
            StWRows, StWCols, StWGie, StWIer, StWStart, StWAck: begin
                if (wr_done) begin
                    if (axi.m_axi_BRESP != 2'b00) begin
                        state_d = StIdle;
                        err_set = 1'b1;
                        err_val = 2'd1;
                    end else begin
                        case (state_q)
                            StWRows:  state_d = StWCols;
                            StWCols:  state_d = StWGie;
                            StWGie:   state_d = StWIer;
                            StWIer:   state_d = StWStart;
                            StWStart: state_d = StWaitIrq;
                            default: begin
                                ack_done = 1'b1;
                                state_d  = StDoneChk;
                            end
                        endcase
                    end
                end
            end
            StWaitIrq: begin
                if (interrupt) begin
                    state_d = StRStat;
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == TmoLast) begin
                    state_d = StIdle;
                    err_set = 1'b1;
                    err_val = 2'd2;
                end
            end
            StRStat: begin
                if (rd_done) begin
                    if (axi.m_axi_RRESP != 2'b00) begin
                        state_d = StIdle;
                        err_set = 1'b1;
                        err_val = 2'd1;
                    end else if (!axi.m_axi_RDATA[1]) begin
                        state_d = StIdle;
                        err_set = 1'b1;
                        err_val = 2'd3;
                    end else begin
                        state_d = StWAck;
                    end
                end
            end
            StDoneChk: begin
                if (stop_pend_q || (num_q != 16'd0 && frames_q == num_q)) state_d = StIdle;
                else state_d = StWStart;
            end
            default: state_d = StIdle;
        endcase

        // Every write/read state is entered from a different state, so entry issues the access.
        if (state_d != state_q) begin
            unique case (state_d)
                StWRows:  begin wr_issue = 1'b1; wr_addr = RegRows; wr_data = DATA_WIDTH'(frame_rows); end
                StWCols:  begin wr_issue = 1'b1; wr_addr = RegCols; wr_data = DATA_WIDTH'(cols_q); end
                StWGie:   begin wr_issue = 1'b1; wr_addr = RegGie;  wr_data = One; end
                StWIer:   begin wr_issue = 1'b1; wr_addr = RegIer;  wr_data = One; end
                StWStart: begin wr_issue = 1'b1; wr_addr = RegCtrl; wr_data = One; end
                StWAck:   begin wr_issue = 1'b1; wr_addr = RegIsr;  wr_data = One; end
                StRStat:  rd_issue = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            cols_q      <= '0;
            num_q       <= '0;
            frames_q    <= '0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
            stop_pend_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                cols_q   <= frame_cols;
                num_q    <= num_frames;
                frames_q <= '0;
                err_q    <= 1'b0;
                code_q   <= 2'd0;
            end else begin
                if (ack_done) frames_q <= frames_q + 16'd1;
                if (err_set) begin
                    err_q  <= 1'b1;
                    code_q <= err_val;
                end
            end
            if (state_d == StIdle && state_q != StIdle) stop_pend_q <= 1'b0;
            else if (stop && (state_q != StIdle || start)) stop_pend_q <= 1'b1;
            if (state_q == StWStart) tmo_q <= '0;
            else if (state_q == StWaitIrq) tmo_q <= tmo_q + 32'd1;
        end
    end

    // AW and W retire independently; B is only accepted once both have been taken.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            if (wr_issue) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                awaddr_q  <= wr_addr;
                wdata_q   <= wr_data;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                bready_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    awvalid_q <= 1'b0;
                    aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                    wvalid_q <= 1'b0;
                    w_done_q <= 1'b1;
                end
                if (wr_done) begin
                    bready_q  <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end else if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    bready_q <= 1'b1;
                end
            end
            if (rd_issue) begin
                arvalid_q <= 1'b1;
                rready_q  <= 1'b0;
            end else begin
                if (ar_hs) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                if (rd_done) rready_q <= 1'b0;
            end
        end
    end

    assign axi.m_axi_AWADDR  = awaddr_q;
    assign axi.m_axi_AWVALID = awvalid_q;
    assign axi.m_axi_WDATA   = wdata_q;
    assign axi.m_axi_WSTRB   = 4'hF;
    assign axi.m_axi_WVALID  = wvalid_q;
    assign axi.m_axi_BREADY  = bready_q;
    assign axi.m_axi_ARADDR  = RegCtrl;
    assign axi.m_axi_ARVALID = arvalid_q;
    assign axi.m_axi_RREADY  = rready_q;

    assign busy        = (state_q != StIdle);
    assign frames_done = frames_q;
    assign error       = err_q;
    assign err_code    = code_q;
endmodule

// File: tb/tb_image_proc_frame_sequencer.sv
// Bench for image_proc_frame_sequencer: an AXI-Lite slave model feeds a scoreboard of
// expected control-bus accesses; a second instance with a short timeout covers WAIT_IRQ expiry.
module tb_image_proc_frame_sequencer;
    logic        aclk = 1'b0;
    logic        areset;
    logic        start, stop, interrupt;
    logic [15:0] frame_rows, frame_cols, num_frames;
    logic        busy, error;
    logic [15:0] frames_done;
    logic [1:0]  err_code;
    logic        t_start, t_busy, t_error;
    logic [15:0] t_frames_done;
    logic [1:0]  t_err_code;

    always #5 aclk = ~aclk;

    image_proc_frame_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();
    image_proc_frame_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) t_axi ();

    image_proc_frame_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop),
        .frame_rows(frame_rows), .frame_cols(frame_cols), .num_frames(num_frames),
        .interrupt(interrupt), .axi(axi), .busy(busy), .frames_done(frames_done),
        .error(error), .err_code(err_code)
    );

    image_proc_frame_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(50)) dut_tmo (
        .aclk(aclk), .areset(areset), .start(t_start), .stop(1'b0),
        .frame_rows(16'd8), .frame_cols(16'd8), .num_frames(16'd1),
        .interrupt(1'b0), .axi(t_axi), .busy(t_busy), .frames_done(t_frames_done),
        .error(t_error), .err_code(t_err_code)
    );

    // Always-ready, always-OKAY slave; the core never interrupts, so only the timeout can end a run.
    assign t_axi.m_axi_AWREADY = 1'b1;
    assign t_axi.m_axi_WREADY  = 1'b1;
    assign t_axi.m_axi_BVALID  = 1'b1;
    assign t_axi.m_axi_BRESP   = 2'b00;
    assign t_axi.m_axi_ARREADY = 1'b1;
    assign t_axi.m_axi_RVALID  = 1'b1;
    assign t_axi.m_axi_RDATA   = 32'h0;
    assign t_axi.m_axi_RRESP   = 2'b00;

    typedef struct packed {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;
    txn_t sb[$];

    int n_cmp = 0, n_fail = 0;
    int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int irq_cnt = 0, b_cnt = 0, st_cnt = 0;
    bit got_aw = 0, got_w = 0, got_ar = 0, ar_block = 0, irq_level = 0;
    bit bresp_inject = 0, bready_early = 0, aw_drop_indep = 0, rw_overlap = 0;
    logic [4:0]  cur_awaddr = '0, cur_araddr = '0, bresp_addr = '0;
    logic [31:0] cur_wdata = '0, rd_val = 32'h2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rd, input logic [4:0] a, input logic [31:0] d);
        txn_t t;
        t.rd = rd; t.addr = a; t.data = d;
        sb.push_back(t);
    endtask

    task automatic push_setup(input logic [15:0] r, input logic [15:0] c);
        push(1'b0, 5'h10, 32'(r));
        push(1'b0, 5'h14, 32'(c));
        push(1'b0, 5'h04, 32'h1);
        push(1'b0, 5'h08, 32'h1);
    endtask

    task automatic push_frame();
        push(1'b0, 5'h00, 32'h1);
        push(1'b1, 5'h00, rd_val);
        push(1'b0, 5'h0C, 32'h1);
    endtask

    task automatic sb_check(input logic rd, input logic [4:0] a, input logic [31:0] d);
        txn_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected access: got rd=%0d addr=0x%0h data=0x%0h, required none",
                     rd, a, d);
        end else begin
            e = sb.pop_front();
            check("access kind", 32'(rd), 32'(e.rd));
            check(rd ? "read addr" : "write addr", 32'(a), 32'(e.addr));
            check(rd ? "read data" : "write data", d, e.data);
        end
    endtask

    // Handshake monitor and slave state; sees pre-edge DUT outputs.
    always @(posedge aclk) begin
        if (areset) begin
            got_aw = 0; got_w = 0; got_ar = 0; aw_wait = 0; w_wait = 0;
            irq_cnt = 0; irq_level = 0;
        end else begin
            if (axi.m_axi_BREADY && !(got_aw && got_w)) bready_early = 1;
            if (got_aw && !axi.m_axi_AWVALID && axi.m_axi_WVALID) aw_drop_indep = 1;
            if (axi.m_axi_ARVALID && (axi.m_axi_AWVALID || axi.m_axi_WVALID || axi.m_axi_BREADY))
                rw_overlap = 1;
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) irq_level = 1;
            end
            if (axi.m_axi_AWVALID && axi.m_axi_AWREADY) begin
                got_aw = 1; cur_awaddr = axi.m_axi_AWADDR; aw_wait = 0;
            end else if (axi.m_axi_AWVALID) aw_wait++;
            if (axi.m_axi_WVALID && axi.m_axi_WREADY) begin
                got_w = 1; cur_wdata = axi.m_axi_WDATA; w_wait = 0;
            end else if (axi.m_axi_WVALID) w_wait++;
            if (axi.m_axi_BVALID && axi.m_axi_BREADY) begin
                b_cnt++;
                if (cur_awaddr == 5'h00) begin st_cnt++; irq_cnt = 100; end
                if (cur_awaddr == 5'h0C) irq_level = 0;
                sb_check(1'b0, cur_awaddr, cur_wdata);
                got_aw = 0; got_w = 0;
            end
            if (axi.m_axi_ARVALID && axi.m_axi_ARREADY) begin
                got_ar = 1; cur_araddr = axi.m_axi_ARADDR;
            end
            if (axi.m_axi_RVALID && axi.m_axi_RREADY) begin
                sb_check(1'b1, cur_araddr, axi.m_axi_RDATA);
                got_ar = 0;
            end
        end
    end

    always @(negedge aclk) begin
        axi.m_axi_AWREADY = axi.m_axi_AWVALID && !got_aw && aw_wait >= aw_delay;
        axi.m_axi_WREADY  = axi.m_axi_WVALID && !got_w && w_wait >= w_delay;
        axi.m_axi_BVALID  = got_aw && got_w;
        axi.m_axi_BRESP   = (bresp_inject && cur_awaddr == bresp_addr) ? 2'b10 : 2'b00;
        axi.m_axi_ARREADY = axi.m_axi_ARVALID && !ar_block && !got_ar;
        axi.m_axi_RVALID  = got_ar;
        axi.m_axi_RDATA   = got_ar ? rd_val : 32'h0;
        axi.m_axi_RRESP   = 2'b00;
        interrupt         = irq_level;
    end

    task automatic run(input logic [15:0] r, input logic [15:0] c, input logic [15:0] f,
                       input logic with_stop);
        @(negedge aclk);
        frame_rows = r; frame_cols = c; num_frames = f; start = 1'b1; stop = with_stop;
        @(negedge aclk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle wait: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (st_cnt < target && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check("ap_start writes seen", 32'(st_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        areset = 1'b1; start = 1'b0; stop = 1'b0; t_start = 1'b0;
        frame_rows = '0; frame_cols = '0; num_frames = '0; interrupt = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset outputs", {frames_done, 12'h0, error, err_code, 1'b0},
              32'h0);
        check("reset valids", {27'h0, axi.m_axi_AWVALID, axi.m_axi_WVALID, axi.m_axi_BREADY,
              axi.m_axi_ARVALID, axi.m_axi_RREADY}, 32'h0);
        areset = 1'b0;

        // Two-frame run with a zero-wait slave.
        push_setup(16'd480, 16'd640);
        push_frame();
        push_frame();
        run(16'd480, 16'd640, 16'd2, 1'b0);
        check("busy after start", 32'(busy), 32'h1);
        wait_idle(1000);
        check("t1 frames_done", 32'(frames_done), 32'd2);
        check("t1 error", {30'h0, error, 1'b0} | 32'(err_code), 32'h0);
        check("t1 leftover", 32'(sb.size()), 32'd0);

        // Slow AW/W ready: channels must retire independently, one B per write.
        aw_delay = 3; w_delay = 7; b_cnt = 0; aw_drop_indep = 0;
        push_setup(16'd10, 16'd20);
        push_frame();
        run(16'd10, 16'd20, 16'd1, 1'b0);
        wait_idle(1000);
        check("t2 awvalid dropped before wvalid", 32'(aw_drop_indep), 32'h1);
        check("t2 bready early", 32'(bready_early), 32'h0);
        check("t2 B count", 32'(b_cnt), 32'd6);
        check("t2 frames_done", 32'(frames_done), 32'd1);
        check("t2 leftover", 32'(sb.size()), 32'd0);
        aw_delay = 0; w_delay = 0;

        // Continuous run, stop during the third frame's interrupt wait.
        st_cnt = 0;
        push_setup(16'd4, 16'd5);
        repeat (3) push_frame();
        run(16'd4, 16'd5, 16'd0, 1'b0);
        wait_starts(3, 1500);
        repeat (20) @(negedge aclk);
        stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        wait_idle(1000);
        check("t3 frames_done", 32'(frames_done), 32'd3);
        check("t3 error", 32'(error), 32'h0);
        check("t3 leftover", 32'(sb.size()), 32'd0);

        // SLVERR on the GIE write aborts the run before IER.
        bresp_inject = 1; bresp_addr = 5'h04;
        push(1'b0, 5'h10, 32'd7);
        push(1'b0, 5'h14, 32'd9);
        push(1'b0, 5'h04, 32'h1);
        run(16'd7, 16'd9, 16'd1, 1'b0);
        wait_idle(200);
        repeat (10) @(negedge aclk);
        check("t5 error", 32'(error), 32'h1);
        check("t5 err_code", 32'(err_code), 32'd1);
        check("t5 leftover", 32'(sb.size()), 32'd0);
        bresp_inject = 0;

        // Status readback without ap_done.
        rd_val = 32'h0;
        push_setup(16'd3, 16'd3);
        push(1'b0, 5'h00, 32'h1);
        push(1'b1, 5'h00, 32'h0);
        run(16'd3, 16'd3, 16'd1, 1'b0);
        wait_idle(1000);
        check("t8 error", 32'(error), 32'h1);
        check("t8 err_code", 32'(err_code), 32'd3);
        check("t8 frames_done", 32'(frames_done), 32'd0);
        check("t8 leftover", 32'(sb.size()), 32'd0);
        rd_val = 32'h2;
        irq_level = 0;

        // start and stop together from IDLE: exactly one frame, and start clears the old error.
        push_setup(16'd2, 16'd2);
        push_frame();
        run(16'd2, 16'd2, 16'd0, 1'b1);
        check("t7 error cleared", 32'(error), 32'h0);
        wait_idle(1000);
        check("t7 frames_done", 32'(frames_done), 32'd1);
        check("t7 leftover", 32'(sb.size()), 32'd0);

        // Reset while the second frame's status read is stalled on ARREADY.
        st_cnt = 0;
        push_setup(16'd6, 16'd6);
        push_frame();
        push_frame();
        run(16'd6, 16'd6, 16'd2, 1'b0);
        wait_starts(2, 1000);
        ar_block = 1;
        n = 0;
        while (axi.m_axi_ARVALID !== 1'b1 && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("t6 arvalid before reset", 32'(axi.m_axi_ARVALID), 32'h1);
        check("t6 frames_done before reset", 32'(frames_done), 32'd1);
        areset = 1'b1;
        #1;
        check("t6 valids after reset", {27'h0, axi.m_axi_AWVALID, axi.m_axi_WVALID,
              axi.m_axi_BREADY, axi.m_axi_ARVALID, axi.m_axi_RREADY}, 32'h0);
        check("t6 status after reset", {busy, error, err_code, 12'h0, frames_done}, 32'h0);
        check("t6 addr after reset", {axi.m_axi_AWADDR, 27'h0}, 32'h0);
        check("t6 wdata after reset", axi.m_axi_WDATA, 32'h0);
        repeat (3) @(negedge aclk);
        sb.delete();
        ar_block = 0;
        areset = 1'b0;
        push_setup(16'd12, 16'd13);
        push_frame();
        run(16'd12, 16'd13, 16'd1, 1'b0);
        wait_idle(1000);
        check("t6 rerun frames_done", 32'(frames_done), 32'd1);
        check("t6 rerun error", 32'(error), 32'h0);
        check("t6 leftover", 32'(sb.size()), 32'd0);
        check("read/write overlap", 32'(rw_overlap), 32'h0);

        // Timeout instance: 5 two-cycle writes + 50 WAIT_IRQ cycles = 60 busy cycles.
        @(negedge aclk);
        t_start = 1'b1;
        @(negedge aclk);
        t_start = 1'b0;
        n = 0;
        while (t_busy === 1'b1 && n < 500) begin
            n++;
            @(negedge aclk);
        end
        check("tmo busy cycles", 32'(n), 32'd60);
        check("tmo error", 32'(t_error), 32'h1);
        check("tmo err_code", 32'(t_err_code), 32'd2);
        t_start = 1'b1;
        @(negedge aclk);
        t_start = 1'b0;
        check("tmo restart clears error", {30'h0, t_error, t_busy}, 32'h1);
        check("tmo restart clears err_code", 32'(t_err_code), 32'd0);
        n = 0;
        while (t_busy === 1'b1 && n < 500) begin
            n++;
            @(negedge aclk);
        end
        check("tmo second expiry", 32'(t_err_code), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
